// File: rtl/spi_slave.sv
// spi_slave: SPI target, CPHA=0, oversampled in the clk domain.
// Optional SPI_SLAVE_ERR_COUNT_EN enables the saturating err_count.
//
// Ports:
//   clk, n_rst           system clock, async active-low reset
//   spi_sclk/ss_n/mosi   SPI pins from the master (asynchronous)
//   spi_miso/miso_oe     SPI data back to the master, output enable
//   tx_data_in/valid_in  TX word stream in (tx_ready_out = buffer empty)
//   rx_data_out/valid    RX word stream out (rx_ready_in accepts)
//   overrun_out          one-cycle pulse when an RX word is dropped
//   err_count            dropped-word count (0 when counter disabled)
module spi_slave #(
    parameter int unsigned          DATA_BITS = 8,
    parameter bit                   CPOL      = 1'b0,
    parameter bit                   LSBF      = 1'b0,
    parameter logic [DATA_BITS-1:0] IDLE_FILL = '1
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 spi_sclk,
    input  logic                 spi_ss_n,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    output logic                 spi_miso_oe,
    input  logic [DATA_BITS-1:0] tx_data_in,
    input  logic                 tx_valid_in,
    output logic                 tx_ready_out,
    output logic [DATA_BITS-1:0] rx_data_out,
    output logic                 rx_valid_out,
    input  logic                 rx_ready_in,
    output logic                 overrun_out,
    output logic [7:0]           err_count
);

    localparam int CW = $clog2(DATA_BITS + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t state, state_nx;

    logic [1:0] sclk_sy, ss_sy, mosi_sy;
    logic       sclk_q, ss_q;
    logic       sclk_s, ss_s, mosi_s;
    logic       lead, trail, ss_fall;

    logic [DATA_BITS-1:0] tx_buf, tx_sr, rx_sr, tx_word;
    logic                 tx_full;
    logic [CW-1:0]        bit_cnt;
    logic                 drop;

    assign sclk_s  = sclk_sy[1];
    assign ss_s    = ss_sy[1];
    assign mosi_s  = mosi_sy[1];
    assign lead    = CPOL ? (sclk_q & ~sclk_s) : (~sclk_q & sclk_s);
    assign trail   = CPOL ? (~sclk_q & sclk_s) : (sclk_q & ~sclk_s);
    assign ss_fall = ss_q & ~ss_s;

    assign tx_ready_out = ~tx_full;
    assign tx_word      = tx_full ? tx_buf : IDLE_FILL;
    assign drop         = (state == DONE) && rx_valid_out && !rx_ready_in;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sclk_sy <= {2{CPOL}};
            ss_sy   <= 2'b11;
            mosi_sy <= 2'b00;
            sclk_q  <= CPOL;
            ss_q    <= 1'b1;
        end else begin
            sclk_sy <= {sclk_sy[0], spi_sclk};
            ss_sy   <= {ss_sy[0], spi_ss_n};
            mosi_sy <= {mosi_sy[0], spi_mosi};
            sclk_q  <= sclk_s;
            ss_q    <= ss_s;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (ss_fall) state_nx = LOAD;
            LOAD:  state_nx = SHIFT;
            SHIFT: begin
                if (ss_s)
                    state_nx = IDLE;
                else if (lead && bit_cnt == CW'(DATA_BITS - 1))
                    state_nx = DONE;
            end
            DONE:  state_nx = ss_s ? IDLE : LOAD;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tx_buf  <= '0;
            tx_full <= 1'b0;
        end else if (tx_valid_in && !tx_full) begin
            tx_buf  <= tx_data_in;
            tx_full <= 1'b1;
        end else if (state == LOAD) begin
            tx_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tx_sr       <= '0;
            rx_sr       <= '0;
            bit_cnt     <= '0;
            spi_miso    <= 1'b1;
            spi_miso_oe <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    spi_miso    <= 1'b1;
                    spi_miso_oe <= 1'b0;
                end
                LOAD: begin
                    tx_sr       <= tx_word;
                    spi_miso    <= LSBF ? tx_word[0] : tx_word[DATA_BITS-1];
                    spi_miso_oe <= 1'b1;
                    bit_cnt     <= '0;
                end
                SHIFT: begin
                    if (ss_s) begin
                        spi_miso    <= 1'b1;
                        spi_miso_oe <= 1'b0;
                    end else begin
                        if (lead) begin
                            bit_cnt <= bit_cnt + CW'(1);
                            if (LSBF) rx_sr <= {mosi_s, rx_sr[DATA_BITS-1:1]};
                            else      rx_sr <= {rx_sr[DATA_BITS-2:0], mosi_s};
                        end
                        // At count 0 the pending trailing edge belongs to the
                        // previous word; LOAD already drove the first bit.
                        if (trail && bit_cnt != '0) begin
                            if (LSBF) begin
                                tx_sr    <= tx_sr >> 1;
                                spi_miso <= tx_sr[1];
                            end else begin
                                tx_sr    <= tx_sr << 1;
                                spi_miso <= tx_sr[DATA_BITS-2];
                            end
                        end
                    end
                end
                DONE: if (ss_s) spi_miso <= 1'b1;
                default: ;
            endcase
            if (ss_s) spi_miso_oe <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_data_out  <= '0;
            rx_valid_out <= 1'b0;
            overrun_out  <= 1'b0;
        end else begin
            overrun_out <= drop;
            if (state == DONE && (!rx_valid_out || rx_ready_in)) begin
                rx_data_out  <= rx_sr;
                rx_valid_out <= 1'b1;
            end else if (rx_valid_out && rx_ready_in) begin
                rx_valid_out <= 1'b0;
            end
        end
    end

`ifdef SPI_SLAVE_ERR_COUNT_EN
    logic [7:0] err_q;
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            err_q <= 8'd0;
        else if (drop && err_q != 8'hFF)
            err_q <= err_q + 8'd1;
    end
    assign err_count = err_q;
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed bench for spi_slave with an RX scoreboard.
// Drives an 8-bit CPOL0/MSBF instance and a 16-bit CPOL1/LSBF instance.
module tb_spi_slave;

    localparam int HALF = 50;

    logic        clk = 1'b0;
    logic        n_rst;

    logic        sclk8, ss8, mosi8, miso8, oe8;
    logic [7:0]  txd8, rx8, err8;
    logic        txv8, txr8, rxv8, rxr8, ovr8;

    logic        sclk16, ss16, mosi16, miso16, oe16;
    logic [15:0] txd16, rx16;
    logic [7:0]  err16;
    logic        txv16, txr16, rxv16, rxr16, ovr16;

    int errors = 0;
    int checks = 0;
    int ovr_cnt = 0;
    logic [31:0] rxq[$];
    logic        txr_at_load;

    always #5 clk = ~clk;

    always @(posedge clk) if (ovr8) ovr_cnt <= ovr_cnt + 1;

    spi_slave u_dut8 (
        .clk(clk), .n_rst(n_rst),
        .spi_sclk(sclk8), .spi_ss_n(ss8), .spi_mosi(mosi8),
        .spi_miso(miso8), .spi_miso_oe(oe8),
        .tx_data_in(txd8), .tx_valid_in(txv8), .tx_ready_out(txr8),
        .rx_data_out(rx8), .rx_valid_out(rxv8), .rx_ready_in(rxr8),
        .overrun_out(ovr8), .err_count(err8)
    );

    spi_slave #(.DATA_BITS(16), .CPOL(1'b1), .LSBF(1'b1)) u_dut16 (
        .clk(clk), .n_rst(n_rst),
        .spi_sclk(sclk16), .spi_ss_n(ss16), .spi_mosi(mosi16),
        .spi_miso(miso16), .spi_miso_oe(oe16),
        .tx_data_in(txd16), .tx_valid_in(txv16), .tx_ready_out(txr16),
        .rx_data_out(rx16), .rx_valid_out(rxv16), .rx_ready_in(rxr16),
        .overrun_out(ovr16), .err_count(err16)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic load_tx(input int which, input logic [15:0] w);
        @(negedge clk);
        if (which == 0) begin txd8 = w[7:0]; txv8 = 1'b1; end
        else begin txd16 = w; txv16 = 1'b1; end
        @(negedge clk);
        txv8  = 1'b0;
        txv16 = 1'b0;
    endtask

    task automatic frame_start(input int which, input string tag);
        bit seen;
        seen = 0;
        @(negedge clk);
        if (which == 0) ss8 = 1'b0; else ss16 = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = (which == 0) ? oe8 : oe16;
            txr_at_load = (which == 0) ? txr8 : txr16;
        end
        chk({tag, "_oe_on"}, 32'(seen), 32'd1);
    endtask

    task automatic word(input int which, input logic [31:0] mw,
                        input int nbits, output logic [31:0] sw);
        int idx;
        sw = '0;
        for (int k = 0; k < nbits; k++) begin
            idx = (which == 0) ? 7 - k : k;
            if (which == 0) mosi8 = mw[idx]; else mosi16 = mw[idx];
            #(HALF);
            if (which == 0) begin sclk8 = 1'b1; sw[idx] = miso8; end
            else begin sclk16 = 1'b0; sw[idx] = miso16; end
            #(HALF);
            if (which == 0) sclk8 = 1'b0; else sclk16 = 1'b1;
        end
    endtask

    task automatic frame_end(input int which);
        #(HALF);
        if (which == 0) ss8 = 1'b1; else ss16 = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic wait_rx(input int which, input string tag);
        logic [31:0] exp_w;
        bit got;
        got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            got = (which == 0) ? rxv8 : rxv16;
        end
        chk({tag, "_valid"}, 32'(got), 32'd1);
        exp_w = (rxq.size() != 0) ? rxq.pop_front() : 32'hDEAD_BEEF;
        chk({tag, "_data"}, (which == 0) ? 32'(rx8) : 32'(rx16), exp_w);
        if (which == 0) rxr8 = 1'b1; else rxr16 = 1'b1;
        @(negedge clk);
        rxr8  = 1'b0;
        rxr16 = 1'b0;
        @(negedge clk);
        chk({tag, "_clr"}, (which == 0) ? 32'(rxv8) : 32'(rxv16), 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        int ob;
        n_rst = 1'b0;
        sclk8 = 1'b0; ss8 = 1'b1; mosi8 = 1'b0;
        sclk16 = 1'b1; ss16 = 1'b1; mosi16 = 1'b0;
        txd8 = '0; txv8 = 1'b0; rxr8 = 1'b0;
        txd16 = '0; txv16 = 1'b0; rxr16 = 1'b0;
        txr_at_load = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_miso", 32'(miso8), 32'd1);
        chk("rst_oe", 32'(oe8), 32'd0);
        chk("rst_txr", 32'(txr8), 32'd1);
        chk("rst_rxv", 32'(rxv8), 32'd0);
        chk("rst_rxd", 32'(rx8), 32'd0);
        chk("rst_ovr", 32'(ovr8), 32'd0);
        chk("rst_err", 32'(err8), 32'd0);
        chk("rst_oe16", 32'(oe16), 32'd0);
        n_rst = 1'b1;
        repeat (5) @(negedge clk);

        // Buffered TX word, normal exchange
        load_tx(0, 16'h00A5);
        chk("t1_txr_busy", 32'(txr8), 32'd0);
        rxq.push_back(32'h3C);
        frame_start(0, "t1");
        chk("t1_txr_load", 32'(txr_at_load), 32'd1);
        word(0, 32'h3C, 8, r);
        frame_end(0);
        chk("t1_miso", r, 32'hA5);
        wait_rx(0, "t1_rx");

        // Empty TX buffer shifts the idle fill
        rxq.push_back(32'h96);
        frame_start(0, "t2");
        word(0, 32'h96, 8, r);
        frame_end(0);
        chk("t2_miso", r, 32'hFF);
        wait_rx(0, "t2_rx");

        // Two words in one frame with no consumer
        ob = ovr_cnt;
        rxq.push_back(32'h11);
        frame_start(0, "t3");
        word(0, 32'h11, 8, r);
        word(0, 32'h22, 8, r);
        frame_end(0);
        chk("t3_miso2", r, 32'hFF);
        chk("t3_rxv", 32'(rxv8), 32'd1);
        chk("t3_rxd", 32'(rx8), 32'h11);
        chk("t3_ovr", 32'(ovr_cnt - ob), 32'd1);
`ifdef SPI_SLAVE_ERR_COUNT_EN
        chk("t3_err", 32'(err8), 32'd1);
`else
        chk("t3_err", 32'(err8), 32'd0);
`endif
        wait_rx(0, "t3_rx");

        // Aborted word after 5 bits
        ob = ovr_cnt;
        frame_start(0, "t4");
        word(0, 32'hF0, 5, r);
        @(negedge clk);
        ss8 = 1'b1;
        repeat (4) @(negedge clk);
        chk("t4_oe_off", 32'(oe8), 32'd0);
        chk("t4_miso_idle", 32'(miso8), 32'd1);
        repeat (10) @(negedge clk);
        chk("t4_rxv", 32'(rxv8), 32'd0);
        chk("t4_ovr", 32'(ovr_cnt - ob), 32'd0);
        rxq.push_back(32'h5A);
        frame_start(0, "t4b");
        word(0, 32'h5A, 8, r);
        frame_end(0);
        wait_rx(0, "t4_rx");

        // 16-bit, CPOL=1, LSB first
        load_tx(1, 16'h1234);
        rxq.push_back(32'h8001);
        frame_start(1, "t5");
        word(1, 32'h8001, 16, r);
        frame_end(1);
        chk("t5_miso", r, 32'h1234);
        wait_rx(1, "t5_rx");

        // Reset pulsed mid-word
        load_tx(0, 16'h0077);
        frame_start(0, "t6");
        load_tx(0, 16'h0099);
        word(0, 32'hAA, 3, r);
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        chk("t6_miso", 32'(miso8), 32'd1);
        chk("t6_oe", 32'(oe8), 32'd0);
        chk("t6_txr", 32'(txr8), 32'd1);
        chk("t6_rxv", 32'(rxv8), 32'd0);
        chk("t6_err", 32'(err8), 32'd0);
        ss8 = 1'b1;
        sclk8 = 1'b0;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        repeat (5) @(negedge clk);
        rxq.push_back(32'hC3);
        frame_start(0, "t6b");
        word(0, 32'hC3, 8, r);
        frame_end(0);
        chk("t6_miso_fill", r, 32'hFF);
        wait_rx(0, "t6_rx");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
